// File: rtl/alu_share_ctrl_pkg.sv
// alu_share_ctrl_pkg: shared widths, ALU function codes and controller states
package alu_share_ctrl_pkg;

    localparam int OPW  = 4;
    localparam int FNW  = 3;
    localparam int RESW = 8;

    localparam logic [FNW-1:0] FN_ADD_RC  = 3'b000;
    localparam logic [FNW-1:0] FN_ADD_MOD = 3'b001;
    localparam logic [FNW-1:0] FN_SEXT_B  = 3'b010;
    localparam logic [FNW-1:0] FN_OR_RED  = 3'b011;
    localparam logic [FNW-1:0] FN_AND_RED = 3'b100;
    localparam logic [FNW-1:0] FN_CONCAT  = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/alu_share_ctrl_alu4.sv
// alu_share_ctrl_alu4: combinational 4-bit ALU built around one ripple-carry adder
module alu_share_ctrl_alu4
    import alu_share_ctrl_pkg::*;
(
    input  logic [OPW-1:0]  i_a,
    input  logic [OPW-1:0]  i_b,
    input  logic [FNW-1:0]  i_fn,
    output logic [RESW-1:0] o_y
);

    logic [OPW:0]   w_c;
    logic [OPW-1:0] w_s;

    assign w_c[0] = 1'b0;

    for (genvar i = 0; i < OPW; i++) begin : g_fa
        assign w_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    // select the operation; both add codes share the single adder chain
    always_comb begin
        o_y = '0;
        case (i_fn)
            FN_ADD_RC:  o_y = {3'b000, w_c[OPW], w_s};
            FN_ADD_MOD: o_y = {4'b0000, w_s};
            FN_SEXT_B:  o_y = {{4{i_b[OPW-1]}}, i_b};
            FN_OR_RED:  o_y = {7'd0, |{i_a, i_b}};
            FN_AND_RED: o_y = {7'd0, &{i_a, i_b}};
            FN_CONCAT:  o_y = {i_a, i_b};
            default:    o_y = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin time-sharing of one 4-bit ALU between two clients
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            req0,
    input  logic            req1,
    input  logic [OPW-1:0]  a0,
    input  logic [OPW-1:0]  b0,
    input  logic [OPW-1:0]  a1,
    input  logic [OPW-1:0]  b1,
    input  logic [FNW-1:0]  fn0,
    input  logic [FNW-1:0]  fn1,
    output logic            ack0,
    output logic            ack1,
    output logic            done0,
    output logic            done1,
    output logic [RESW-1:0] result,
    output logic            busy
);

    state_t          r_state;
    logic            r_owner;
    logic            r_last;
    logic [OPW-1:0]  r_a;
    logic [OPW-1:0]  r_b;
    logic [FNW-1:0]  r_fn;
    logic            w_pick1;
    logic [RESW-1:0] w_y;

    // client 1 wins when alone, or on a tie when client 0 was served last
    assign w_pick1 = req1 & (~req0 | ~r_last);

    alu_share_ctrl_alu4 u_alu (
        .i_a  (r_a),
        .i_b  (r_b),
        .i_fn (r_fn),
        .o_y  (w_y)
    );

    // grant/execute FSM; handshakes are single-cycle registered pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_a     <= '0;
            r_b     <= '0;
            r_fn    <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            busy    <= 1'b0;
            result  <= '0;
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req0 | req1) begin
                        r_owner <= w_pick1;
                        r_a     <= w_pick1 ? a1 : a0;
                        r_b     <= w_pick1 ? b1 : b0;
                        r_fn    <= w_pick1 ? fn1 : fn0;
                        ack0    <= ~w_pick1;
                        ack1    <= w_pick1;
                        busy    <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result  <= w_y;
                    done0   <= ~r_owner;
                    done1   <= r_owner;
                    r_last  <= r_owner;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: randomized scoreboard bench for the shared ALU controller
module tb_alu_share_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [2:0] fn0 = '0, fn1 = '0;
    logic       ack0, ack1, done0, done1, busy;
    logic [7:0] result;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic       owner;
        logic [7:0] res;
        int         due;
    } exp_t;

    exp_t q[$];
    int   order[$];

    alu_share_ctrl dut (
        .clock  (clock),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .a0     (a0),
        .b0     (b0),
        .a1     (a1),
        .b1     (b1),
        .fn0    (fn0),
        .fn1    (fn1),
        .ack0   (ack0),
        .ack1   (ack1),
        .done0  (done0),
        .done1  (done1),
        .result (result),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference ALU from plain integer arithmetic
    function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] fn);
        int sa = int'(a);
        int sb = int'(b);
        case (fn)
            3'd0:    return 8'(sa + sb);
            3'd1:    return 8'((sa + sb) % 16);
            3'd2:    return 8'(sb >= 8 ? sb + 240 : sb);
            3'd3:    return (sa + sb) != 0 ? 8'h01 : 8'h00;
            3'd4:    return (sa == 15 && sb == 15) ? 8'h01 : 8'h00;
            3'd5:    return 8'(sa * 16 + sb);
            default: return 8'h00;
        endcase
    endfunction

    // predictor: inputs seen at the previous edge decide who is granted now
    logic       p_rst = 1'b1, p_r0 = 1'b0, p_r1 = 1'b0;
    logic [3:0] p_a0, p_b0, p_a1, p_b1;
    logic [2:0] p_fn0, p_fn1;
    logic       model_last = 1'b1;
    logic       prev_grant = 1'b0;
    logic       grant, win;

    always @(negedge clock) begin
        cyc++;
        if (p_rst) begin
            chk("reset_outputs", {27'd0, ack0, ack1, done0, done1, busy}, 32'd0);
            chk("reset_result", {24'd0, result}, 32'd0);
            q.delete();
            model_last = 1'b1;
            prev_grant = 1'b0;
        end else begin
            grant = !prev_grant && (p_r0 || p_r1);
            win   = (p_r0 && p_r1) ? !model_last : p_r1;
            chk("ack", {30'd0, ack1, ack0}, grant ? (win ? 32'd2 : 32'd1) : 32'd0);
            chk("busy", {31'd0, busy}, {31'd0, grant});
            if (grant) begin
                q.push_back('{owner: win,
                              res: win ? ref_alu(p_a1, p_b1, p_fn1) : ref_alu(p_a0, p_b0, p_fn0),
                              due: cyc + 1});
                model_last = win;
            end
            prev_grant = grant;
        end
        p_rst = reset;
        p_r0  = req0;
        p_r1  = req1;
        p_a0  = a0;
        p_b0  = b0;
        p_fn0 = fn0;
        p_a1  = a1;
        p_b1  = b1;
        p_fn1 = fn1;
    end

    // monitor: pops the scoreboard whenever a done pulse appears
    always @(negedge clock) begin
        exp_t e;
        #1;
        if (done0 || done1) begin
            if (q.size() == 0) begin
                chk("done_unexpected", {30'd0, done1, done0}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc, e.due);
                chk("done_owner", {30'd0, done1, done0}, e.owner ? 32'd2 : 32'd1);
                chk("result", {24'd0, result}, {24'd0, e.res});
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            chk("done_missing", {30'd0, done1, done0}, q[0].owner ? 32'd2 : 32'd1);
            void'(q.pop_front());
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // one request round: each client drops req and scrambles its operands on ack
    task automatic txn(input logic r0, input logic r1,
                       input logic [3:0] xa0, input logic [3:0] xb0, input logic [2:0] xf0,
                       input logic [3:0] xa1, input logic [3:0] xb1, input logic [2:0] xf1);
        a0 = xa0; b0 = xb0; fn0 = xf0;
        a1 = xa1; b1 = xb1; fn1 = xf1;
        req0 = r0;
        req1 = r1;
        for (int n = 0; n < 12 && (req0 || req1); n++) begin
            step();
            if (ack0) begin
                order.push_back(0);
                req0 = 1'b0;
                a0 = ~a0;
                b0 = 4'($urandom);
            end
            if (ack1) begin
                order.push_back(1);
                req1 = 1'b0;
                a1 = ~a1;
                b1 = 4'($urandom);
            end
        end
        if (req0 || req1) begin
            chk("ack_timeout", {30'd0, req1, req0}, 32'd0);
            req0 = 1'b0;
            req1 = 1'b0;
        end
        step();
    endtask

    initial begin
        logic [1:0] pat;
        repeat (3) step();
        reset = 1'b0;
        step();

        txn(1, 0, 4'h9, 4'h8, 3'b000, 4'h0, 4'h0, 3'b000);
        chk("tp_add_rc", {24'd0, result}, 32'h11);
        txn(0, 1, 4'h0, 4'h0, 3'b000, 4'h9, 4'h8, 3'b001);
        chk("tp_add_mod", {24'd0, result}, 32'h01);
        txn(0, 1, 4'h0, 4'h0, 3'b000, 4'h9, 4'hA, 3'b010);
        chk("tp_sext_b", {24'd0, result}, 32'hFA);

        order.delete();
        a0 = 4'h3; b0 = 4'hC; fn0 = 3'b101;
        a1 = 4'hF; b1 = 4'hF; fn1 = 3'b100;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step();
            if (ack0) order.push_back(0);
            if (ack1) order.push_back(1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
        chk("hold_grants", order.size(), 32'd4);
        for (int i = 0; i < order.size(); i++) chk("hold_order", order[i], i % 2);

        txn(1, 0, 4'h0, 4'h0, 3'b011, 4'h0, 4'h0, 3'b000);
        chk("tp_or_zero", {24'd0, result}, 32'h00);
        txn(1, 0, 4'h3, 4'hC, 3'b101, 4'h0, 4'h0, 3'b000);
        chk("tp_concat", {24'd0, result}, 32'h3C);
        txn(1, 0, 4'hF, 4'hE, 3'b100, 4'h0, 4'h0, 3'b000);
        chk("tp_and_fe", {24'd0, result}, 32'h00);
        txn(0, 1, 4'h0, 4'h0, 3'b000, 4'h9, 4'h8, 3'b000);
        chk("tp_add_rc1", {24'd0, result}, 32'h11);
        txn(0, 1, 4'h0, 4'h0, 3'b000, 4'h5, 4'h5, 3'b111);
        chk("tp_fn7", {24'd0, result}, 32'h00);

        txn(1, 0, 4'h9, 4'h1, 3'b101, 4'h0, 4'h0, 3'b000);
        chk("tp_operand_hold", {24'd0, result}, 32'h91);

        order.delete();
        a0 = 4'h1; b0 = 4'h2; fn0 = 3'b101;
        a1 = 4'h4; b1 = 4'h5; fn1 = 3'b101;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int n = 0; n < 6 && !(ack0 || ack1); n++) step();
        chk("abort_tie_winner", {30'd0, ack1, ack0}, 32'd2);
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        chk("abort_done", {30'd0, done1, done0}, 32'd0);
        chk("abort_result", {24'd0, result}, 32'h00);
        reset = 1'b0;
        order.delete();
        txn(1, 1, 4'h6, 4'h7, 3'b101, 4'h8, 4'h9, 3'b101);
        chk("post_reset_first", order.size() > 0 ? order[0] : 32'd9, 32'd0);
        chk("post_reset_result", {24'd0, result}, 32'h89);

        repeat (40) begin
            pat = 2'($urandom_range(1, 3));
            txn(pat[0], pat[1], 4'($urandom), 4'($urandom), 3'($urandom),
                4'($urandom), 4'($urandom), 3'($urandom));
            if ($urandom_range(0, 1) == 1) step();
        end

        repeat (4) step();
        chk("queue_drain", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester controller that time-shares a single 4-bit ALU between two independent clients. It arbitrates round-robin, captures the winner's operands and function code, executes one operation, and returns a registered 8-bit result with per-requester ack/done pulses. It sits between board-level operand sources (switch banks or upstream FSMs) and the hex/LED display path, which read `result`.

## Interface
Parameters: none. Widths are fixed at 4-bit operands, 3-bit function and 8-bit result.

Ports:
- `clock`  in  1  single clock, rising-edge.
- `reset`  in  1  synchronous, active-high.
- `req0`, `req1`  in  1  request from client 0 or 1; hold high until the matching ack.
- `a0`, `b0`, `a1`, `b1`  in  4  operands per client; sampled at the grant edge.
- `fn0`, `fn1`  in  3  function code per client; sampled at the grant edge.
- `ack0`, `ack1`  out  1  one-cycle pulse; operands captured and request consumed.
- `done0`, `done1`  out  1  one-cycle pulse; `result` valid for this client.
- `result`  out  8  last completed ALU output; held until the next completion.
- `busy`  out  1  high while an operation is in flight (state EXEC).

## Operation
- FSM states: IDLE, EXEC.
- **IDLE:**
  - If any `req` is high at the edge, pick a winner. If only one requests, it wins. If both request, the client not served last wins.
  - Latch `a`/`b`/`fn` into operand registers and record the owner. Set the owner's `ack` and `busy` for the next cycle, then go to EXEC.
  - If no request, stay in IDLE.
- **EXEC:**
  - The ALU evaluates the latched operands combinationally.
  - At the edge: `result` <= ALU output, the owner's `done` = 1 for the next cycle, `last_served` <= owner, `busy` <= 0, go to IDLE.
  - Requests present during EXEC are ignored; no queuing.
- Function codes (result is always 8 bits, zero-extended unless stated):
  - 000 ADD_RC: ripple-carry sum, {3'b0, cout, sum[3:0]}.
  - 001 ADD_MOD: {4'b0, (A+B) mod 16}.
  - 010 SEXT_B: {4{B[3]}, B}.
  - 011 OR_RED: 8'h01 if any bit of A or B is 1, else 8'h00.
  - 100 AND_RED: 8'h01 only if all 8 bits of A and B are 1, else 8'h00.
  - 101 CONCAT: {A, B}.
  - 110 and 111: 8'h00; still completes with `done`.
- Clients must drop `req` in the cycle `ack` is seen. A `req` still high when the FSM returns to IDLE is treated as a new request.

## Timing
- Reset values: state = IDLE, `ack0` = `ack1` = `done0` = `done1` = 0, `busy` = 0, `result` = 8'h00, operand registers = 0, `last_served` = 1 (client 0 wins the first tie).
- Latency, with request sampled at edge k:
  - `ack` and `busy` high in cycle k+1.
  - `done` high and new `result` visible in cycle k+2.
- Throughput: one operation per 2 cycles. A new grant can occur at the edge ending the `done` cycle.
- `ack` and `done` are never high for both clients in the same cycle. `ack` and `done` for one operation never overlap.
- Back-to-back: with both `req`s held high continuously, grants alternate 0, 1, 0, 1.
- Reset asserted during EXEC:
  - The operation is aborted with no `done`.
  - `result` returns to 8'h00.
  - The arbiter pointer returns to favour client 0.
- Operands changing after the grant edge have no effect on the in-flight operation.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared header `alu_defs.vh`:
  - function-code localparams (FN_ADD_RC … FN_CONCAT);
  - state encodings ST_IDLE, ST_EXEC;
  - widths OPW = 4, FNW = 3, RESW = 8.
- Sub-module `alu4`: purely combinational ALU containing the 4-bit ripple-carry adder built from full-adder cells. It is instantiated once, which makes the sharing explicit.
- Top module: FSM, round-robin pointer, operand/owner registers, output registers.

## Test plan
- Reset, then `req0` with a0 = 4'h9, b0 = 4'h8, fn0 = 000 -> `ack0` at k+1, `done0` at k+2, `result` = 8'h11; `busy` high only in k+1.
- Client 1 alone with a1 = 4'h9, b1 = 4'h8, fn1 = 001 -> `result` = 8'h01; then fn1 = 010, b1 = 4'hA -> `result` = 8'hFA.
- Both requests held for 8 cycles (fn0 = 101, a0 = 4'h3, b0 = 4'hC; fn1 = 100, all ones) -> grant order 0, 1, 0, 1; results alternate 8'h3C and 8'h01.
- OR_RED on all-zero operands -> 8'h00; AND_RED with a = 4'hF, b = 4'hE -> 8'h00; fn = 111 -> 8'h00 with `done` still pulsed.
- `reset` asserted in the EXEC cycle -> no `done`, `result` = 8'h00 next cycle; after release, a tie is granted to client 0.
- Operands changed in the `ack` cycle (a0 = 4'h9 to 4'h0) -> `result` reflects the captured values only.
